pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program counter and instruction address width.
REQ-002 Parameter RS_DEPTH, default 4, number of return-stack entries.
REQ-003 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port imem_req, output, 1, instruction fetch request; high exactly while in FETCH.
REQ-006 Port imem_addr, output, PC_W, fetch address; equals pc.
REQ-007 Port imem_ready, input, 1, instruction memory has valid data on imem_data this cycle.
REQ-008 Port imem_data, input, 16, fetched instruction word.
REQ-009 Port state, output, 1, sequencing phase for the control decoder: 0 = FETCH, 1 = EXEC; also 0 in HALT.
REQ-010 Port opcode, output, 4, ir[15:12].
REQ-011 Port eoe, output, 4, ir[3:0].
REQ-012 Port ir, output, 16, instruction register.
REQ-013 Port ps, input, 2, PC select from the decoder: 00 stop, 01 increment, 10 relative jump, 11 return.
REQ-014 Port il, input, 1, execute-cycle qualifier; the PC update and stack operation occur only when il=1.
REQ-015 Port mp, input, 1, push the link address onto the return stack.
REQ-016 Port pc, output, PC_W, current program counter.
REQ-017 Port link_pc, output, PC_W, pc+1 modulo 2^PC_W; the register-file write data when mp=1.
REQ-018 Port halted, output, 1, high in HALT.
REQ-019 Port stack_err, output, 1, sticky return-stack overflow/underflow flag.
REQ-020 Port stack_depth, output, 3, number of valid return-stack entries (0..RS_DEPTH).

Function
REQ-021 The FSM SHALL have three states: FETCH, EXEC and HALT.
REQ-022 In FETCH, when imem_ready=1 the block SHALL load ir <= imem_data and go to EXEC on the same edge; otherwise it stays in FETCH with ir unchanged, for any number of wait cycles.
REQ-023 In EXEC with il=0, the block SHALL hold pc, stack and ir, and remain in EXEC.
REQ-024 In EXEC with il=1, the ps actions SHALL be:
- ps=01: pc <= pc+1, go to FETCH.
- ps=10: pc <= pc + sign-extended ir[7:0], go to FETCH.
- ps=11: pop, go to FETCH.
- ps=00: pc held, go to HALT.
REQ-025 All pc arithmetic SHALL be modulo 2^PC_W (255+1 -> 0; 2 + 0xFC -> 254).
REQ-026 A pop SHALL set pc <= top entry and decrement the depth; a pop on an empty stack SHALL instead set pc <= pc+1 and set stack_err.
REQ-027 mp=1 with il=1 in EXEC SHALL push link_pc and increment the depth; a push when depth=RS_DEPTH SHALL be dropped, set stack_err, leave the stack unchanged, and still apply the ps action.
REQ-028 If mp=1 and ps=11 in the same EXEC cycle, the pop SHALL read the pre-push top and the push SHALL then write link_pc into that same slot, so the depth is unchanged.
REQ-029 mp SHALL be ignored outside EXEC or when il=0.
REQ-030 HALT SHALL be terminal until rst_n is asserted; all inputs are ignored in HALT.
REQ-031 EXEC SHALL last exactly one cycle when il=1, so the minimum instruction period is 2 cycles.
REQ-032 stack_err SHALL remain set until reset.

Reset
REQ-033 While rst_n=0, the following SHALL hold immediately, without waiting for a clock edge:
- pc=0, ir=0, FSM in FETCH (state=0, imem_req=1, halted=0).
- stack_depth=0, stack_err=0.
- Stack entries: don't-care.
REQ-034 Assertion of rst_n in any state, including mid-wait in FETCH or mid-EXEC, SHALL abandon the operation with no partial pc or stack update.
REQ-035 After rst_n deasserts, the first fetch SHALL present imem_addr=0.

Verification
REQ-036 Reset release with imem_ready held 1, drive ps=01, il=1 in every EXEC -> pc steps 0,1,2,3, one step per 2 cycles; imem_req alternates 1/0.
REQ-037 imem_ready held low 5 cycles in FETCH -> state=0 and ir unchanged throughout; the word 0x8A05 then loads, giving opcode=8, eoe=5.
REQ-038 pc=10, ir[7:0]=0xF8, ps=10 -> pc=2; pc=255, ps=01 -> pc=0.
REQ-039 Call/return sequence:
- At pc=20: mp=1, ps=10, offset 0x10 -> pc=36, depth=1, link_pc was 21.
- Later ps=11 -> pc=21, depth=0.
- A further ps=11 -> pc=22, stack_err=1.
REQ-040 Five pushes with RS_DEPTH=4 -> depth=4 and stack_err=1; the fifth jump is still taken; then four pops return the first four link addresses in LIFO order.
REQ-041 ps=00 in EXEC -> halted=1 and state=0, with pc frozen for 20 cycles under random inputs; rst_n pulsed low mid-HALT -> pc=0 and FETCH, asynchronously.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute/halt FSM with relative jumps and a
// small return stack for call/return.
module pc_sequencer #(
  parameter int PC_W     = 8,
  parameter int RS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [15:0]     imem_data,
  output logic            state,
  output logic [3:0]      opcode,
  output logic [3:0]      eoe,
  output logic [15:0]     ir,
  input  logic [1:0]      ps,
  input  logic            il,
  input  logic            mp,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link_pc,
  output logic            halted,
  output logic            stack_err,
  output logic [2:0]      stack_depth
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [2:0]        r_depth;
  logic              r_err;
  logic [PC_W-1:0]   r_stack [RS_DEPTH];

  logic signed [7:0] w_off8;
  logic [PC_W-1:0]   w_offset;
  logic [PC_W-1:0]   w_link;
  logic [PC_W-1:0]   w_jump;
  logic              w_exec_go;
  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_top_idx;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [2:0]        w_depth_nxt;
  logic              w_err_set;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;

  assign w_off8    = r_ir[7:0];
  assign w_offset  = PC_W'(w_off8);
  assign w_link    = r_pc + PC_W'(1);
  assign w_jump    = r_pc + w_offset;
  assign w_exec_go = (r_state == S_EXEC) && il;
  assign w_empty   = (r_depth == 3'd0);
  assign w_full    = (r_depth == 3'(RS_DEPTH));
  assign w_top_idx = IDX_W'(r_depth - 3'd1);

  // Next pc / stack action for an executing instruction. A push combined with a
  // valid pop overwrites the slot just popped, so the depth stays put.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_err_set   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = IDX_W'(r_depth);
    case (ps)
      2'b01: w_pc_nxt = w_link;
      2'b10: w_pc_nxt = w_jump;
      2'b11: begin
        if (w_empty) begin
          w_pc_nxt  = w_link;
          w_err_set = 1'b1;
        end else begin
          w_pc_nxt    = r_stack[w_top_idx];
          w_depth_nxt = r_depth - 3'd1;
        end
      end
      default: w_pc_nxt = r_pc;
    endcase
    if (mp) begin
      if (ps == 2'b11 && !w_empty) begin
        w_wr_en     = 1'b1;
        w_wr_idx    = w_top_idx;
        w_depth_nxt = r_depth;
      end else if (w_full) begin
        w_err_set = 1'b1;
      end else begin
        w_wr_en     = 1'b1;
        w_wr_idx    = IDX_W'(r_depth);
        w_depth_nxt = r_depth + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_depth <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (il) begin
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            if (w_err_set) r_err <= 1'b1;
            r_state <= (ps == 2'b00) ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Stack contents are pure data; only depth qualifies which entries are live.
  always_ff @(posedge clk) begin
    if (w_exec_go && w_wr_en) r_stack[w_wr_idx] <= w_link;
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign state       = (r_state == S_EXEC);
  assign halted      = (r_state == S_HALT);
  assign opcode      = r_ir[15:12];
  assign eoe         = r_ir[3:0];
  assign ir          = r_ir;
  assign pc          = r_pc;
  assign link_pc     = w_link;
  assign stack_err   = r_err;
  assign stack_depth = r_depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of instructions with hand-derived results fed
// through a scoreboard queue, plus wait-state, halt and async-reset sequences.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        state;
  logic [3:0]  opcode;
  logic [3:0]  eoe;
  logic [15:0] ir;
  logic [1:0]  ps;
  logic        il;
  logic        mp;
  logic [7:0]  pc;
  logic [7:0]  link_pc;
  logic        halted;
  logic        stack_err;
  logic [2:0]  stack_depth;

  pc_sequencer #(.PC_W(8), .RS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .state(state),
    .opcode(opcode), .eoe(eoe), .ir(ir), .ps(ps), .il(il), .mp(mp),
    .pc(pc), .link_pc(link_pc), .halted(halted), .stack_err(stack_err),
    .stack_depth(stack_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] word;
    logic [1:0]  ps;
    logic        mp;
    logic [7:0]  pc;
    logic [2:0]  depth;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] depth;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk;
  int   n_err;
  logic [7:0] cur_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_depth", 32'(stack_depth), 32'd0);
    chk("rst_err", 32'(stack_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cur_pc = 8'd0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(cur_pc));
    imem_ready = 1'b1;
    imem_data  = v.word;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_data  = 16'($urandom);
    chk("exec_state", 32'(state), 32'd1);
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("exec_ir", 32'(ir), 32'(v.word));
    chk("link_pc", 32'(link_pc), 32'(8'(cur_pc + 8'd1)));
    ps = v.ps;
    il = 1'b1;
    mp = v.mp;
    sb.push_back('{pc: v.pc, depth: v.depth, err: v.err});
    @(posedge clk); #1;
    il = 1'b0;
    mp = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc", 32'(pc), 32'(e.pc));
      chk("depth", 32'(stack_depth), 32'(e.depth));
      chk("err", 32'(stack_err), 32'(e.err));
      chk("back_to_fetch", 32'(state), 32'd0);
      cur_pc = e.pc;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    imem_data  = 16'h0000;
    ps = 2'b01;
    il = 1'b0;
    mp = 1'b0;
    cur_pc = 8'd0;

    //             rst   word      ps     mp    pc      depth err
    vecs.push_back('{1'b1, 16'h1000, 2'd1, 1'b0, 8'd1,   3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h1000, 2'd1, 1'b0, 8'd2,   3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h1000, 2'd1, 1'b0, 8'd3,   3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h2007, 2'd2, 1'b0, 8'd10,  3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h20F8, 2'd2, 1'b0, 8'd2,   3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h207F, 2'd2, 1'b0, 8'd129, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h207E, 2'd2, 1'b0, 8'd255, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h1000, 2'd1, 1'b0, 8'd0,   3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h2014, 2'd2, 1'b0, 8'd20,  3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h2010, 2'd2, 1'b1, 8'd36,  3'd1, 1'b0});
    vecs.push_back('{1'b0, 16'h1000, 2'd1, 1'b0, 8'd37,  3'd1, 1'b0});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd21,  3'd0, 1'b0});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd22,  3'd0, 1'b1});
    vecs.push_back('{1'b0, 16'h20EC, 2'd2, 1'b0, 8'd2,   3'd0, 1'b1});
    vecs.push_back('{1'b0, 16'h20FC, 2'd2, 1'b0, 8'd254, 3'd0, 1'b1});
    vecs.push_back('{1'b1, 16'h2010, 2'd2, 1'b1, 8'd16,  3'd1, 1'b0});
    vecs.push_back('{1'b0, 16'h2010, 2'd2, 1'b1, 8'd32,  3'd2, 1'b0});
    vecs.push_back('{1'b0, 16'h2010, 2'd2, 1'b1, 8'd48,  3'd3, 1'b0});
    vecs.push_back('{1'b0, 16'h2010, 2'd2, 1'b1, 8'd64,  3'd4, 1'b0});
    vecs.push_back('{1'b0, 16'h2010, 2'd2, 1'b1, 8'd80,  3'd4, 1'b1});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd49,  3'd3, 1'b1});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd33,  3'd2, 1'b1});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd17,  3'd1, 1'b1});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd1,   3'd0, 1'b1});
    vecs.push_back('{1'b0, 16'h2004, 2'd2, 1'b1, 8'd5,   3'd1, 1'b1});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b1, 8'd2,   3'd1, 1'b1});
    vecs.push_back('{1'b0, 16'h3000, 2'd3, 1'b0, 8'd6,   3'd0, 1'b1});

    // Reset values before any clock edge, then a fetch held off by wait states.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      imem_data = 16'($urandom);
      @(posedge clk); #1;
      chk("wait_state", 32'(state), 32'd0);
      chk("wait_ir", 32'(ir), 32'd0);
      chk("wait_req", 32'(imem_req), 32'd1);
    end
    imem_ready = 1'b1;
    imem_data  = 16'h8A05;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    chk("load_ir", 32'(ir), 32'h8A05);
    chk("opcode", 32'(opcode), 32'd8);
    chk("eoe", 32'(eoe), 32'd5);
    chk("load_state", 32'(state), 32'd1);

    // EXEC without il: everything holds, mp ignored.
    il = 1'b0;
    mp = 1'b1;
    ps = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_state", 32'(state), 32'd1);
      chk("hold_pc", 32'(pc), 32'd0);
      chk("hold_depth", 32'(stack_depth), 32'd0);
      chk("hold_ir", 32'(ir), 32'h8A05);
    end
    mp = 1'b0;
    // Reset mid-EXEC with a live increment request must not move pc.
    il = 1'b1;
    #2;
    apply_reset();
    il = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) apply_reset();
      run_vec(vecs[i]);
    end

    // Halt, then random inputs must not disturb anything.
    imem_ready = 1'b1;
    imem_data  = 16'h0000;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    ps = 2'b00;
    il = 1'b1;
    mp = 1'b0;
    @(posedge clk); #1;
    chk("halted", 32'(halted), 32'd1);
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_pc", 32'(pc), 32'd6);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom);
      imem_data  = 16'($urandom);
      ps = 2'($urandom);
      il = 1'($urandom);
      mp = 1'($urandom);
      @(posedge clk); #1;
      chk("halt_frozen_pc", 32'(pc), 32'd6);
      chk("halt_stays", 32'(halted), 32'd1);
      chk("halt_depth", 32'(stack_depth), 32'd0);
    end
    // Asynchronous reset out of HALT, sampled between edges.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_req", 32'(imem_req), 32'd1);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_err", 32'(stack_err), 32'd0);
    chk("async_depth", 32'(stack_depth), 32'd0);
    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
